// File: rtl/calc_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_seq_pkg - op encodings and sequencer state type
// Rev 1.0
// ----------------------------------------------------------------------------
package calc_seq_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL2 = 2'b10;
  localparam logic [1:0] OP_DIV2 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_FIRE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/calc_op_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_op_sequencer_if - command, control and datapath-side signals
// Rev 1.0
// ----------------------------------------------------------------------------
interface calc_op_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          run;
  logic          abort;
  logic          dp_err;
  logic [1:0]    dp_op_sel;
  logic [7:0]    dp_data;
  logic          dp_calc;
  logic          busy;
  logic          halted;
  logic          done;
  logic [FW-1:0] fill;
  logic [7:0]    exec_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, run, abort, dp_err,
    input  cmd_ready, dp_op_sel, dp_data, dp_calc, busy, halted, done, fill, exec_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, run, abort, dp_err,
    output cmd_ready, dp_op_sel, dp_data, dp_calc, busy, halted, done, fill, exec_count
  );

endinterface
`default_nettype wire

// File: rtl/calc_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_cmd_fifo - command FIFO with flush and a peek at the entry after head
// Rev 1.0
// ----------------------------------------------------------------------------
module calc_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [WIDTH-1:0]           next_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     fill_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [FW-1:0]    fill_q;
  logic             push_d;
  logic             pop_d;

  // Flush wins over a same-cycle push or pop.
  assign push_d = push_i && !full_o && !flush_i;
  assign pop_d  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else if (flush_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push_d) wr_q <= wr_q + AW'(1);
      if (pop_d)  rd_q <= rd_q + AW'(1);
      fill_q <= fill_q + FW'(push_d) - FW'(pop_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_d) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_q + AW'(1)];
  assign full_o  = (fill_q == FW'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;

endmodule
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_op_sequencer - replays queued (op, operand) commands onto the
// accumulator datapath with setup/settle spacing; halts on first error.
// Rev 1.0
// ----------------------------------------------------------------------------
module calc_op_sequencer
  import calc_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SETUP  = 3,
  parameter int SETTLE = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  calc_op_sequencer_if.slave bus
);
  localparam int FW      = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (SETUP > SETTLE) ? SETUP : SETTLE;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic [7:0]    data_q;
  logic          calc_q;
  logic          done_q;
  logic [7:0]    exec_q;

  logic          push_d;
  logic          pop_d;
  logic          flush_d;
  logic [9:0]    head_w;
  logic [9:0]    next_w;
  logic          full_w;
  logic          empty_w;
  logic [FW-1:0] fill_w;

  assign bus.cmd_ready = !full_w && (state_q != ST_HALT);
  assign push_d  = bus.cmd_valid && bus.cmd_ready;
  assign flush_d = bus.abort || ((state_q == ST_CHECK) && bus.dp_err);
  assign pop_d   = (state_q == ST_CHECK) && !bus.dp_err && !bus.abort;

  calc_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_d),
    .pop_i   (pop_d),
    .flush_i (flush_d),
    .data_i  ({bus.cmd_op, bus.cmd_data}),
    .head_o  (head_w),
    .next_o  (next_w),
    .full_o  (full_w),
    .empty_o (empty_w),
    .fill_o  (fill_w)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      calc_q  <= 1'b0;
      done_q  <= 1'b0;
      exec_q  <= '0;
    end else begin
      calc_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= ST_IDLE;
        exec_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // A stale datapath error blocks launching anything.
            if (!empty_w && bus.run) begin
              if (bus.dp_err) begin
                state_q <= ST_HALT;
              end else begin
                state_q <= ST_SETUP;
                cnt_q   <= SETUP_LAST;
                op_q    <= head_w[9:8];
                data_q  <= head_w[7:0];
              end
            end
          end
          ST_SETUP: begin
            if (cnt_q == '0) begin
              state_q <= ST_FIRE;
              calc_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_FIRE: begin
            state_q <= ST_SETTLE;
            cnt_q   <= SETTLE_LAST;
          end
          ST_SETTLE: begin
            if (cnt_q == '0) state_q <= ST_CHECK;
            else             cnt_q   <= cnt_q - CW'(1);
          end
          ST_CHECK: begin
            if (bus.dp_err) begin
              state_q <= ST_HALT;
            end else begin
              if (exec_q != 8'hFF) exec_q <= exec_q + 8'd1;
              // The head is popped this edge, so the next command is one behind it.
              if ((fill_w > FW'(1)) && bus.run) begin
                state_q <= ST_SETUP;
                cnt_q   <= SETUP_LAST;
                op_q    <= next_w[9:8];
                data_q  <= next_w[7:0];
              end else begin
                state_q <= ST_IDLE;
                done_q  <= (fill_w == FW'(1)) && !push_d;
              end
            end
          end
          ST_HALT: state_q <= ST_HALT;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.dp_op_sel  = op_q;
  assign bus.dp_data    = data_q;
  assign bus.dp_calc    = calc_q && !bus.abort;
  assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.done       = done_q;
  assign bus.fill       = fill_w;
  assign bus.exec_count = exec_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_calc_op_sequencer - directed bench with a command-order/datapath model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_calc_op_sequencer;
  import calc_seq_pkg::*;

  localparam int DEPTH  = 8;
  localparam int SETUP  = 3;
  localparam int SETTLE = 2;
  localparam int PERIOD = SETUP + SETTLE + 2;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] d;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

  calc_op_sequencer #(
    .DEPTH  (DEPTH),
    .SETUP  (SETUP),
    .SETTLE (SETTLE)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath model: 8-bit signed accumulator, sticky overflow error.
  logic [7:0] acc_q;
  logic       ovf_q;
  logic       dp_rst;
  logic       force_err;
  int         dp_r;

  function automatic int dp_apply(input int a, input logic [1:0] op, input int d);
    int r;
    case (op)
      OP_ADD:  r = a + d;
      OP_SUB:  r = a - d;
      OP_MUL2: r = a * 2;
      default: r = a >>> 1;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (dp_rst) begin
      acc_q <= 8'd0;
      ovf_q <= 1'b0;
    end else if (bus.dp_calc) begin
      dp_r = dp_apply(int'($signed(acc_q)), bus.dp_op_sel, int'($signed(bus.dp_data)));
      acc_q <= dp_r[7:0];
      if (dp_r > 127 || dp_r < -128) ovf_q <= 1'b1;
    end
  end
  assign bus.dp_err = ovf_q | force_err;

  // Expected firing order and observed event history.
  cmd_t       exp_q[$];
  int         fire_t[$];
  int         n_fire    = 0;
  int         n_done    = 0;
  int         last_done = -1;
  int         stable    = 0;
  logic       prev_calc = 1'b0;
  logic [9:0] prev_od   = 10'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if ({bus.dp_op_sel, bus.dp_data} != prev_od) stable = 1;
      else                                         stable++;
      prev_od = {bus.dp_op_sel, bus.dp_data};
      if (bus.dp_calc) begin
        chk("calc_back_to_back", prev_calc, 0);
        chk("operand_setup", stable > SETUP, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL calc_unexpected: got dp_calc=1, expected no pending command (cycle %0d)", cyc);
        end else begin
          chk("calc_op", bus.dp_op_sel, exp_q[0].op);
          chk("calc_data", bus.dp_data, exp_q[0].d);
          void'(exp_q.pop_front());
        end
        n_fire++;
        fire_t.push_back(cyc);
      end
      if (bus.done) begin
        n_done++;
        last_done = cyc;
      end
      if (bus.halted) chk("halted_ready", bus.cmd_ready, 0);
      chk("busy_halted_excl", bus.busy & bus.halted, 0);
      prev_calc = bus.dp_calc;
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] d, input logic exp_acc,
                      output int t);
    @(negedge clk);
    chk("cmd_ready", bus.cmd_ready, exp_acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    t = cyc;
    if (exp_acc) exp_q.push_back('{op: op, d: d});
  endtask

  task automatic wait_fires(input int target, input int budget, input string name);
    int k = 0;
    while (n_fire < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, n_fire, target);
  endtask

  task automatic do_abort();
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic dp_clear();
    @(negedge clk);
    dp_rst = 1'b1;
    @(negedge clk);
    dp_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e1, f0, d0, x0, k;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'd0;
    bus.run       = 1'b0;
    bus.abort     = 1'b0;
    dp_rst        = 1'b1;
    force_err     = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    dp_rst = 1'b0;

    // Reset state
    chk("rst_fill", bus.fill, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_op", bus.dp_op_sel, 0);
    chk("rst_data", bus.dp_data, 0);
    chk("rst_calc", bus.dp_calc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_exec", bus.exec_count, 0);

    // Asynchronous reset in the middle of SETTLE
    bus.run = 1'b1;
    push(OP_ADD, 8'd9, 1'b1, e);
    while (cyc < e + 5) @(negedge clk);
    chk("a_settle_busy", bus.busy, 1);
    chk("a_fired_once", n_fire, 1);
    #2 rst = 1'b1;
    #1;
    chk("a_fill", bus.fill, 0);
    chk("a_ready", bus.cmd_ready, 1);
    chk("a_busy", bus.busy, 0);
    chk("a_op", bus.dp_op_sel, 0);
    chk("a_data", bus.dp_data, 0);
    chk("a_calc", bus.dp_calc, 0);
    chk("a_exec", bus.exec_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    dp_clear();

    // add 5, sub 3, mul2 from acc=0
    f0 = n_fire;
    d0 = n_done;
    push(OP_ADD,  8'd5, 1'b1, e);
    push(OP_SUB,  8'd3, 1'b1, e1);
    push(OP_MUL2, 8'd0, 1'b1, e1);
    wait_fires(f0 + 3, 40, "t1_fires");
    repeat (6) @(negedge clk);
    chk("t1_fire0_t", fire_t[f0],     e + 4);
    chk("t1_fire1_t", fire_t[f0 + 1], e + 4 + PERIOD);
    chk("t1_fire2_t", fire_t[f0 + 2], e + 4 + 2 * PERIOD);
    chk("t1_done_cnt", n_done - d0, 1);
    chk("t1_done_t", last_done, e + 4 + 2 * PERIOD + 4);
    chk("t1_exec", bus.exec_count, 3);
    chk("t1_acc", acc_q, 4);
    chk("t1_fill", bus.fill, 0);
    do_abort();
    chk("t1_abort_exec", bus.exec_count, 0);
    dp_clear();

    // add 100, add 100 (overflow), sub 1
    f0 = n_fire;
    push(OP_ADD, 8'd100, 1'b1, e);
    push(OP_ADD, 8'd100, 1'b1, e);
    push(OP_SUB, 8'd1,   1'b1, e);
    k = 0;
    while (!bus.halted && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("t2_halted", bus.halted, 1);
    chk("t2_fill", bus.fill, 0);
    chk("t2_exec", bus.exec_count, 1);
    chk("t2_ready", bus.cmd_ready, 0);
    chk("t2_busy", bus.busy, 0);
    push(OP_ADD, 8'd1, 1'b0, e);
    repeat (20) @(negedge clk);
    chk("t2_fires", n_fire - f0, 2);
    chk("t2_fill_after_drop", bus.fill, 0);
    do_abort();
    chk("t2_abort_exec", bus.exec_count, 0);
    chk("t2_abort_halted", bus.halted, 0);
    chk("t2_abort_ready", bus.cmd_ready, 1);
    dp_clear();

    // Fill the queue with run low, then drain
    @(negedge clk);
    bus.run = 1'b0;
    f0 = n_fire;
    d0 = n_done;
    push(OP_ADD,  8'd10,   1'b1, e);
    push(OP_SUB,  8'd3,    1'b1, e);
    push(OP_MUL2, 8'd0,    1'b1, e);
    push(OP_DIV2, 8'd0,    1'b1, e);
    push(OP_ADD,  8'd7,    1'b1, e);
    push(OP_SUB,  8'd20,   1'b1, e);
    push(OP_MUL2, 8'd0,    1'b1, e);
    push(OP_DIV2, 8'd0,    1'b1, e);
    push(OP_ADD,  8'd1,    1'b0, e);
    chk("t3_fill_full", bus.fill, DEPTH);
    chk("t3_idle_paused", n_fire - f0, 0);
    @(negedge clk);
    bus.run = 1'b1;
    wait_fires(f0 + 8, 8 * PERIOD + 20, "t3_fires");
    repeat (6) @(negedge clk);
    chk("t3_span", fire_t[f0 + 7] - fire_t[f0], 7 * PERIOD);
    chk("t3_done_cnt", n_done - d0, 1);
    chk("t3_exec", bus.exec_count, 8);
    chk("t3_fill", bus.fill, 0);
    chk("t3_acc", acc_q, 8'hFA);
    chk("t3_no_extra", n_fire - f0, 8);
    dp_clear();

    // run drops during SETUP of command 2 of 4
    @(negedge clk);
    bus.run = 1'b0;
    f0 = n_fire;
    d0 = n_done;
    x0 = bus.exec_count;
    push(OP_ADD, 8'd1, 1'b1, e);
    push(OP_ADD, 8'd2, 1'b1, e);
    push(OP_ADD, 8'd3, 1'b1, e);
    push(OP_ADD, 8'd4, 1'b1, e);
    @(negedge clk);
    bus.run = 1'b1;
    wait_fires(f0 + 1, 30, "t4_first_fire");
    repeat (4) @(negedge clk);
    bus.run = 1'b0;
    chk("t4_busy_setup", bus.busy, 1);
    repeat (20) @(negedge clk);
    chk("t4_paused_fires", n_fire - f0, 2);
    chk("t4_paused_fill", bus.fill, 2);
    chk("t4_paused_busy", bus.busy, 0);
    chk("t4_paused_exec", bus.exec_count - x0, 2);
    chk("t4_paused_done", n_done - d0, 0);
    bus.run = 1'b1;
    wait_fires(f0 + 4, 40, "t4_resume_fires");
    repeat (6) @(negedge clk);
    chk("t4_done_cnt", n_done - d0, 1);
    chk("t4_fill", bus.fill, 0);
    chk("t4_exec", bus.exec_count - x0, 4);
    chk("t4_acc", acc_q, 10);
    dp_clear();

    // Stale error blocks launch
    f0 = n_fire;
    @(negedge clk);
    force_err = 1'b1;
    push(OP_ADD, 8'd1, 1'b1, e);
    repeat (15) @(negedge clk);
    chk("t5_halted", bus.halted, 1);
    chk("t5_no_calc", n_fire - f0, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_ready", bus.cmd_ready, 0);
    do_abort();
    force_err = 1'b0;
    chk("t5_abort_halted", bus.halted, 0);
    chk("t5_abort_fill", bus.fill, 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
